wash_panel_ctrl: RTL and testbench

WASH_PANEL_CTRL -- requirements
Module: wash_panel_ctrl

---
 rtl/wash_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/wash_panel_ctrl.sv | 179 +++++++++++++++++
 tb/tb_wash_panel_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared definitions for the wash panel: panel state encoding and program-select codes.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_RUN      = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_COMPLETE = 3'd4,
    ST_FAULT    = 3'd5
  } panel_state_e;

  localparam logic [1:0] PROG_NORMAL   = 2'b00;
  localparam logic [1:0] PROG_DOUBLE   = 2'b01;
  localparam logic [1:0] PROG_DRY      = 2'b10;
  localparam logic [1:0] PROG_RESERVED = 2'b11;

  localparam logic [7:0] CYCLES_MAX = 8'hFF;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stability debouncer and press pulse.
// The press pulse is high during the cycle in which the last required stable
// sample is taken, so logic clocked by it reacts DEBOUNCE_CYCLES+2 edges after
// the raw input first rises. Releases and short glitches produce no pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  // Synchronize the raw level and count consecutive samples that differ from the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        cnt_q    <= '0;
        stable_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = sync2_q && !stable_q && (cnt_q == LAST);

endmodule

// File: rtl/wash_panel_ctrl.sv
// Front-panel controller for the washing machine: debounced buttons drive a
// small FSM that starts, pauses, cancels and counts wash cycles.
// Optional watchdog: define WASH_PANEL_WATCHDOG_EN to add a RUN-time limit
// that forces FAULT; without it FAULT is unreachable and fault is tied low.
module wash_panel_ctrl
  import wash_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [15:0] WDOG_LIMIT      = 16'd600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_cancel,
  input  logic [1:0] prog_sel,
  input  logic       done,
  output logic       start,
  output logic       double_wash,
  output logic       dry_wash,
  output logic       time_pause,
  output logic       abort,
  output logic       busy,
  output logic       door_lock,
  output logic       fault,
  output logic [7:0] cycles_done
);

  logic rstMeta_q;
  logic rstSync_q;
  logic startPress;
  logic pausePress;
  logic cancelPress;

  panel_state_e state_q, state_d;
  logic         doubleWash_q, doubleWash_d;
  logic         dryWash_q, dryWash_d;
  logic         abort_q, abort_d;
  logic [7:0]   cyclesDone_q, cyclesDone_d;
`ifdef WASH_PANEL_WATCHDOG_EN
  logic [15:0]  wdogCnt_q, wdogCnt_d;
`else
  logic         unusedWdogLimit;
  assign unusedWdogLimit = ^WDOG_LIMIT;
`endif

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstMeta_q <= 1'b0;
      rstSync_q <= 1'b0;
    end else begin
      rstMeta_q <= 1'b1;
      rstSync_q <= rstMeta_q;
    end
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
    .clk(clk), .rst_n(rstSync_q), .btn_i(btn_start), .press_o(startPress)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_pause (
    .clk(clk), .rst_n(rstSync_q), .btn_i(btn_pause), .press_o(pausePress)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_cancel (
    .clk(clk), .rst_n(rstSync_q), .btn_i(btn_cancel), .press_o(cancelPress)
  );

  // Panel state, latched program bits, abort pulse and completed-cycle counter.
  always_ff @(posedge clk or negedge rstSync_q) begin
    if (!rstSync_q) begin
      state_q      <= ST_IDLE;
      doubleWash_q <= 1'b0;
      dryWash_q    <= 1'b0;
      abort_q      <= 1'b0;
      cyclesDone_q <= 8'd0;
`ifdef WASH_PANEL_WATCHDOG_EN
      wdogCnt_q    <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      doubleWash_q <= doubleWash_d;
      dryWash_q    <= dryWash_d;
      abort_q      <= abort_d;
      cyclesDone_q <= cyclesDone_d;
`ifdef WASH_PANEL_WATCHDOG_EN
      wdogCnt_q    <= wdogCnt_d;
`endif
    end
  end

  // Next-state logic; cancel is applied last so it beats done, pause and the watchdog.
  always_comb begin
    state_d      = state_q;
    doubleWash_d = doubleWash_q;
    dryWash_d    = dryWash_q;
    abort_d      = 1'b0;
    cyclesDone_d = cyclesDone_q;
`ifdef WASH_PANEL_WATCHDOG_EN
    wdogCnt_d    = wdogCnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (startPress) begin
          case (prog_sel)
            PROG_NORMAL:   begin state_d = ST_START; doubleWash_d = 1'b0; dryWash_d = 1'b0; end
            PROG_DOUBLE:   begin state_d = ST_START; doubleWash_d = 1'b1; dryWash_d = 1'b0; end
            PROG_DRY:      begin state_d = ST_START; doubleWash_d = 1'b0; dryWash_d = 1'b1; end
            PROG_RESERVED: state_d = ST_IDLE;
          endcase
        end
      end
      ST_START: begin
        state_d = ST_RUN;
`ifdef WASH_PANEL_WATCHDOG_EN
        wdogCnt_d = 16'd0;
`endif
      end
      ST_RUN: begin
`ifdef WASH_PANEL_WATCHDOG_EN
        wdogCnt_d = wdogCnt_q + 16'd1;
`endif
        if (done) begin
          state_d = ST_COMPLETE;
`ifdef WASH_PANEL_WATCHDOG_EN
        end else if (wdogCnt_q == WDOG_LIMIT - 16'd1) begin
          state_d      = ST_FAULT;
          abort_d      = 1'b1;
          doubleWash_d = 1'b0;
          dryWash_d    = 1'b0;
`endif
        end else if (pausePress) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (done) begin
          state_d = ST_COMPLETE;
        end else if (pausePress) begin
          state_d = ST_RUN;
        end
      end
      ST_COMPLETE: begin
        state_d      = ST_IDLE;
        doubleWash_d = 1'b0;
        dryWash_d    = 1'b0;
        if (cyclesDone_q != CYCLES_MAX) begin
          cyclesDone_d = cyclesDone_q + 8'd1;
        end
      end
      ST_FAULT: begin
        if (cancelPress) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cancelPress && (state_q == ST_START || state_q == ST_RUN || state_q == ST_PAUSED)) begin
      state_d      = ST_IDLE;
      abort_d      = 1'b1;
      doubleWash_d = 1'b0;
      dryWash_d    = 1'b0;
    end
  end

  assign start       = (state_q == ST_START);
  assign time_pause  = (state_q == ST_PAUSED);
  assign busy        = (state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign door_lock   = busy || (state_q == ST_FAULT);
  assign double_wash = doubleWash_q;
  assign dry_wash    = dryWash_q;
  assign abort       = abort_q;
  assign cycles_done = cyclesDone_q;
`ifdef WASH_PANEL_WATCHDOG_EN
  assign fault       = (state_q == ST_FAULT);
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Self-checking bench for wash_panel_ctrl with DEBOUNCE_CYCLES=4, WDOG_LIMIT=20.
// Start and abort pulses are predicted into queues when stimulus is driven and
// matched by cycle number when the DUT produces them.
module tb_wash_panel_ctrl;

  localparam int          DEB  = 4;
  localparam logic [15:0] WDOG = 16'd20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnStart = 1'b0;
  logic       btnPause = 1'b0;
  logic       btnCancel = 1'b0;
  logic [1:0] progSel = 2'b00;
  logic       done = 1'b0;
  logic       start, double_wash, dry_wash, time_pause, abort, busy, door_lock, fault;
  logic [7:0] cycles_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int expCount = 0;
  int expStart, expAbort;
  int startQ[$];
  int abortQ[$];

  wash_panel_ctrl #(.DEBOUNCE_CYCLES(DEB), .WDOG_LIMIT(WDOG)) dut (
    .clk(clk), .rst(rst), .btn_start(btnStart), .btn_pause(btnPause),
    .btn_cancel(btnCancel), .prog_sel(progSel), .done(done), .start(start),
    .double_wash(double_wash), .dry_wash(dry_wash), .time_pause(time_pause),
    .abort(abort), .busy(busy), .door_lock(door_lock), .fault(fault),
    .cycles_done(cycles_done)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every start/abort pulse must match the next predicted cycle.
  always @(negedge clk) begin
    if (start === 1'b1) begin
      checks++;
      if (startQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL start_pulse unexpected at cycle %0d", cyc);
      end else begin
        expStart = startQ.pop_front();
        if (cyc !== expStart) begin
          errors++;
          $display("[TB] FAIL start_pulse at cycle %0d, expected cycle %0d", cyc, expStart);
        end
      end
    end
    if (abort === 1'b1) begin
      checks++;
      if (abortQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL abort_pulse unexpected at cycle %0d", cyc);
      end else begin
        expAbort = abortQ.pop_front();
        if (cyc !== expAbort) begin
          errors++;
          $display("[TB] FAIL abort_pulse at cycle %0d, expected cycle %0d", cyc, expAbort);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic nextCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyPress(input int which, input int holdCycles);
    case (which)
      0: btnStart = 1'b1;
      1: btnPause = 1'b1;
      default: btnCancel = 1'b1;
    endcase
    nextCycle(holdCycles);
    btnStart  = 1'b0;
    btnPause  = 1'b0;
    btnCancel = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    nextCycle(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (door_lock !== 1'b0) begin errors++; $display("[TB] FAIL reset_door_lock got %b want 0", door_lock); end
    checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got %b want 0", start); end
    checks++; if (time_pause !== 1'b0) begin errors++; $display("[TB] FAIL reset_time_pause got %b want 0", time_pause); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %b want 0", fault); end
    checks++; if ({double_wash, dry_wash} !== 2'b00) begin errors++; $display("[TB] FAIL reset_prog got %b want 00", {double_wash, dry_wash}); end
    checks++; if (cycles_done !== 8'd0) begin errors++; $display("[TB] FAIL reset_cycles_done got %0d want 0", cycles_done); end
    rst = 1'b1;
    nextCycle(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_start_double();
    progSel = 2'b01;
    startQ.push_back(cyc + DEB + 2);
    applyPress(0, 10);
    checks++; if (double_wash !== 1'b1) begin errors++; $display("[TB] FAIL start_double_wash got %b want 1", double_wash); end
    checks++; if (dry_wash !== 1'b0) begin errors++; $display("[TB] FAIL start_dry_wash got %b want 0", dry_wash); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_busy got %b want 1", busy); end
    checks++; if (door_lock !== 1'b1) begin errors++; $display("[TB] FAIL start_door_lock got %b want 1", door_lock); end
    checks++; if (startQ.size() != 0) begin errors++; $display("[TB] FAIL start_pulse_missing pending %0d want 0", startQ.size()); end
    progSel = 2'b10;
  endtask

  task automatic test_pause();
    applyPress(1, 6);
    checks++; if (time_pause !== 1'b1) begin errors++; $display("[TB] FAIL pause_time_pause got %b want 1", time_pause); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL pause_busy got %b want 1", busy); end
    nextCycle(8);
    checks++; if ({double_wash, dry_wash} !== 2'b10) begin errors++; $display("[TB] FAIL pause_prog_held got %b want 10", {double_wash, dry_wash}); end
    applyPress(1, 6);
    checks++; if (time_pause !== 1'b0) begin errors++; $display("[TB] FAIL resume_time_pause got %b want 0", time_pause); end
    done = 1'b1;
    nextCycle(1);
    done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL complete_busy got %b want 0", busy); end
    checks++; if (door_lock !== 1'b0) begin errors++; $display("[TB] FAIL complete_door_lock got %b want 0", door_lock); end
    nextCycle(1);
    expCount = 1;
    checks++; if (cycles_done !== 8'(expCount)) begin errors++; $display("[TB] FAIL complete_cycles_done got %0d want %0d", cycles_done, expCount); end
    checks++; if ({double_wash, dry_wash} !== 2'b00) begin errors++; $display("[TB] FAIL complete_prog_clear got %b want 00", {double_wash, dry_wash}); end
    nextCycle(6);
  endtask

  task automatic test_glitch();
    progSel = 2'b00;
    applyPress(0, DEB - 1);
    nextCycle(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy got %b want 0", busy); end
    progSel = 2'b11;
    applyPress(0, 8);
    nextCycle(8);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reserved_prog_busy got %b want 0", busy); end
    checks++; if ({double_wash, dry_wash} !== 2'b00) begin errors++; $display("[TB] FAIL reserved_prog_bits got %b want 00", {double_wash, dry_wash}); end
  endtask

  task automatic test_cancel_done();
    progSel = 2'b10;
    startQ.push_back(cyc + DEB + 2);
    applyPress(0, 8);
    checks++; if ({double_wash, dry_wash} !== 2'b01) begin errors++; $display("[TB] FAIL dry_prog got %b want 01", {double_wash, dry_wash}); end
    nextCycle(8);
    btnCancel = 1'b1;
    nextCycle(DEB + 1);
    done = 1'b1;
    abortQ.push_back(cyc + 1);
    nextCycle(1);
    done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_busy got %b want 0", busy); end
    checks++; if (dry_wash !== 1'b0) begin errors++; $display("[TB] FAIL cancel_dry_wash got %b want 0", dry_wash); end
    nextCycle(2);
    btnCancel = 1'b0;
    nextCycle(8);
    checks++; if (cycles_done !== 8'(expCount)) begin errors++; $display("[TB] FAIL cancel_cycles_done got %0d want %0d", cycles_done, expCount); end
    checks++; if (abortQ.size() != 0) begin errors++; $display("[TB] FAIL cancel_abort_missing pending %0d want 0", abortQ.size()); end
  endtask

  task automatic test_watchdog();
    int c0;
    progSel = 2'b00;
    c0 = cyc;
    startQ.push_back(c0 + DEB + 2);
    applyPress(0, 8);
`ifdef WASH_PANEL_WATCHDOG_EN
    nextCycle(18);
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL wdog_early_fault got %b want 0", fault); end
    abortQ.push_back(c0 + 27);
    nextCycle(1);
    checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL wdog_fault got %b want 1", fault); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wdog_busy got %b want 0", busy); end
    nextCycle(10);
    checks++; if (door_lock !== 1'b1) begin errors++; $display("[TB] FAIL wdog_door_lock got %b want 1", door_lock); end
    applyPress(2, 8);
    checks++; if ({fault, door_lock} !== 2'b00) begin errors++; $display("[TB] FAIL wdog_cancel got %b want 00", {fault, door_lock}); end
`else
    nextCycle(40);
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL nowdog_fault got %b want 0", fault); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL nowdog_busy got %b want 1", busy); end
    abortQ.push_back(cyc + DEB + 2);
    applyPress(2, 8);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nowdog_cancel_busy got %b want 0", busy); end
`endif
    nextCycle(8);
    checks++; if (abortQ.size() != 0) begin errors++; $display("[TB] FAIL wdog_abort_missing pending %0d want 0", abortQ.size()); end
  endtask

  task automatic test_reset_midrun();
    progSel = 2'b01;
    startQ.push_back(cyc + DEB + 2);
    applyPress(0, 8);
    checks++; if ({busy, double_wash} !== 2'b11) begin errors++; $display("[TB] FAIL midrun_pre got %b want 11", {busy, double_wash}); end
    nextCycle(2);
    rst = 1'b0;
    #1;
    expCount = 0;
    checks++; if ({start, double_wash, dry_wash, time_pause, abort, busy, door_lock, fault} !== 8'h00) begin
      errors++; $display("[TB] FAIL midrun_reset_outputs got %b want 00000000", {start, double_wash, dry_wash, time_pause, abort, busy, door_lock, fault});
    end
    checks++; if (cycles_done !== 8'd0) begin errors++; $display("[TB] FAIL midrun_reset_cycles_done got %0d want 0", cycles_done); end
    nextCycle(3);
    rst = 1'b1;
    nextCycle(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_post_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    progSel = 2'b00;
    for (int i = 0; i < 257; i++) begin
      startQ.push_back(cyc + DEB + 2);
      applyPress(0, 6);
      done = 1'b1;
      nextCycle(2);
      done = 1'b0;
      if (expCount < 255) expCount++;
      nextCycle(6);
      checks++;
      if (cycles_done !== 8'(expCount)) begin
        errors++;
        $display("[TB] FAIL b2b_cycles_done iter %0d got %0d want %0d", i, cycles_done, expCount);
      end
    end
    checks++; if (startQ.size() != 0) begin errors++; $display("[TB] FAIL b2b_start_missing pending %0d want 0", startQ.size()); end
  endtask

  initial begin
    test_reset();
    test_start_double();
    test_pause();
    test_glitch();
    test_cancel_done();
    test_watchdog();
    test_reset_midrun();
    test_back_to_back();
    nextCycle(4);
    checks++;
    if (startQ.size() != 0 || abortQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_pulses start %0d abort %0d want 0 0", startQ.size(), abortQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
